// File: rtl/wishbone_pkg.sv
// Shared types and defaults for the wishbone master arbiter.
package wishbone_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, TIMEOUT} arb_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority encoder: first set bit of req searching ptr+1, ptr+2, ... modulo N.
// Purely combinational; kept generic so the slave side can reuse it.
module rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;
  int unsigned      sum;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    sum   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      sum  = 32'(ptr) + k;
      cand = IDX_W'(sum % N);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin wishbone master arbiter with per-master lock and a bus watchdog.
// All outputs registered; a grant appears one edge after the request is sampled.
module wishbone_arbiter #(
  parameter int unsigned N_MASTER = 4,
  parameter int unsigned TIMEOUT  = wishbone_pkg::TIMEOUT_DEFAULT,
  parameter int unsigned IDX_W    = $clog2(N_MASTER)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_MASTER-1:0] cyc_i,
  input  logic [N_MASTER-1:0] stb_i,
  input  logic [N_MASTER-1:0] lock_i,
  input  logic                bus_ack_i,
  input  logic                bus_err_i,
  input  logic                bus_rty_i,
  output logic [N_MASTER-1:0] gnt_o,
  output logic [IDX_W-1:0]    gnt_idx_o,
  output logic                gnt_vld_o,
  output logic                to_err_o
);

  import wishbone_pkg::*;

  localparam int unsigned      CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_MASTER - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;
  logic [N_MASTER-1:0] gnt_q, gnt_d;
  logic                gnt_vld_q, gnt_vld_d;
  logic                to_err_q, to_err_d;

  logic [IDX_W-1:0]    win_idx;
  logic                win_found;
  logic                cur_cyc, cur_stb, cur_lock, resp;

  rr_picker #(
    .N     (N_MASTER),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (cyc_i),
    .ptr   (last_q),
    .idx   (win_idx),
    .found (win_found)
  );

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    last_d    = last_q;
    to_cnt_d  = to_cnt_q;
    gnt_vld_d = gnt_vld_q;
    to_err_d  = 1'b0;
    gnt_d     = '0;

    cur_cyc  = cyc_i[gnt_idx_q];
    cur_stb  = stb_i[gnt_idx_q];
    cur_lock = lock_i[gnt_idx_q];
    resp     = bus_ack_i | bus_err_i | bus_rty_i;

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (win_found) begin
          state_d   = GRANT;
          gnt_idx_d = win_idx;
          last_d    = win_idx;
          gnt_vld_d = 1'b1;
        end
      end

      GRANT: begin
        if (!cur_cyc && !cur_lock) begin
          // The current owner has cyc low, so the picker only sees other masters.
          to_cnt_d = '0;
          if (win_found) begin
            gnt_idx_d = win_idx;
            last_d    = win_idx;
          end else begin
            state_d   = IDLE;
            gnt_vld_d = 1'b0;
          end
        end else if ((TIMEOUT != 0) && cur_stb && !resp) begin
          if (to_cnt_q == CNT_MAX) begin
            to_err_d = 1'b1;
            to_cnt_d = '0;
            state_d  = wishbone_pkg::TIMEOUT;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end else begin
          to_cnt_d = '0;
        end
      end

      wishbone_pkg::TIMEOUT: begin
        // Hold the grant until the stalled master gives up; lock cannot extend it.
        to_cnt_d = '0;
        if (!cur_cyc) begin
          state_d   = IDLE;
          gnt_vld_d = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        gnt_vld_d = 1'b0;
        to_cnt_d  = '0;
      end
    endcase

    if (gnt_vld_d) begin
      gnt_d[gnt_idx_d] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      last_q    <= LAST_RST;
      to_cnt_q  <= '0;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      last_q    <= last_d;
      to_cnt_q  <= to_cnt_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      to_err_q  <= to_err_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = gnt_idx_q;
  assign gnt_vld_o = gnt_vld_q;
  assign to_err_o  = to_err_q;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Bench for wishbone_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_wishbone_arbiter;

  localparam int N = 4;
  localparam int T = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [N-1:0] cyc_i = '0, stb_i = '0, lock_i = '0;
  logic         bus_ack_i = 1'b0, bus_err_i = 1'b0, bus_rty_i = 1'b0;

  logic [N-1:0] gnt_o, gnt0_o;
  logic [1:0]   gnt_idx_o, gnt0_idx_o;
  logic         gnt_vld_o, gnt0_vld_o, to_err_o, to_err0_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: current owner (-1 = none), last winner, unanswered-strobe streak.
  int m_owner, m_ptr, m_streak;
  bit m_hung, m_err;

  always #5 clk_i = ~clk_i;

  wishbone_arbiter #(.N_MASTER(N), .TIMEOUT(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .lock_i(lock_i),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rty_i(bus_rty_i),
    .gnt_o(gnt_o), .gnt_idx_o(gnt_idx_o), .gnt_vld_o(gnt_vld_o), .to_err_o(to_err_o)
  );

  wishbone_arbiter #(.N_MASTER(N), .TIMEOUT(0)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .lock_i(lock_i),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rty_i(bus_rty_i),
    .gnt_o(gnt0_o), .gnt_idx_o(gnt0_idx_o), .gnt_vld_o(gnt0_vld_o), .to_err_o(to_err0_o)
  );

  function automatic int rr_pick(logic [N-1:0] req, int from);
    for (int k = 1; k <= N; k++) begin
      if (req[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = N - 1;
    m_streak = 0;
    m_hung   = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_step();
    bit resp;
    int w;
    resp  = bus_ack_i | bus_err_i | bus_rty_i;
    m_err = 1'b0;
    if (rst_i) begin
      model_reset();
    end else if (m_owner < 0) begin
      w = rr_pick(cyc_i, m_ptr);
      if (w >= 0) begin m_owner = w; m_ptr = w; m_streak = 0; end
    end else if (m_hung) begin
      if (!cyc_i[m_owner]) begin m_owner = -1; m_hung = 1'b0; end
    end else if (!cyc_i[m_owner] && !lock_i[m_owner]) begin
      w = rr_pick(cyc_i, m_ptr);
      m_owner  = w;
      if (w >= 0) m_ptr = w;
      m_streak = 0;
    end else if (stb_i[m_owner] && !resp) begin
      m_streak++;
      // Fires on the (T+1)-th consecutive unanswered strobe edge.
      if (m_streak == T + 1) begin m_err = 1'b1; m_hung = 1'b1; m_streak = 0; end
    end else begin
      m_streak = 0;
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cyc_i = '0; stb_i = '0; lock_i = '0;
    bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rty_i = 1'b0;
    model_reset();
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (gnt_o !== 4'b0000) begin n_errors++; $display("FAIL rst_gnt: got %b want 0000", gnt_o); end
    n_checks++; if (gnt_vld_o !== 1'b0) begin n_errors++; $display("FAIL rst_vld: got %b want 0", gnt_vld_o); end
    n_checks++; if (gnt_idx_o !== 2'd0) begin n_errors++; $display("FAIL rst_idx: got %0d want 0", gnt_idx_o); end
    n_checks++; if (to_err_o !== 1'b0) begin n_errors++; $display("FAIL rst_to_err: got %b want 0", to_err_o); end
    do_reset();
    cyc_i = 4'b1010;
    #1;
    n_checks++; if (gnt_o !== 4'b0000) begin n_errors++; $display("FAIL prio_not_comb: got %b want 0000", gnt_o); end
    step();
    n_checks++; if (gnt_o !== 4'b0010) begin n_errors++; $display("FAIL prio_gnt: got %b want 0010", gnt_o); end
    n_checks++; if (gnt_idx_o !== 2'd1) begin n_errors++; $display("FAIL prio_idx: got %0d want 1", gnt_idx_o); end
    n_checks++; if (gnt_vld_o !== 1'b1) begin n_errors++; $display("FAIL prio_vld: got %b want 1", gnt_vld_o); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    do_reset();
    cyc_i = 4'b1111;
    step();
    n_checks++; if (gnt_o !== 4'b0001) begin n_errors++; $display("FAIL rr_first: got %b want 0001", gnt_o); end
    for (int n = 1; n <= 4; n++) begin
      step();
      step();
      cyc_i[(n - 1) % N] = 1'b0;
      step();
      exp = 4'b0001 << (n % N);
      n_checks++; if (gnt_o !== exp) begin n_errors++; $display("FAIL rr_order%0d: got %b want %b", n, gnt_o, exp); end
      n_checks++; if (gnt_vld_o !== 1'b1) begin n_errors++; $display("FAIL rr_no_idle%0d: got %b want 1", n, gnt_vld_o); end
      cyc_i[(n - 1) % N] = 1'b1;
    end
  endtask

  task automatic test_lock();
    do_reset();
    cyc_i = 4'b0100;
    step();
    lock_i = 4'b0100;
    cyc_i  = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (gnt_o !== 4'b0100) begin n_errors++; $display("FAIL lock_hold%0d: got %b want 0100", i, gnt_o); end
    end
    lock_i = 4'b0000;
    step();
    n_checks++; if (gnt_o !== 4'b0001) begin n_errors++; $display("FAIL lock_release: got %b want 0001", gnt_o); end
  endtask

  task automatic test_single();
    do_reset();
    cyc_i = 4'b0001;
    step();
    cyc_i = 4'b0000;
    step();
    n_checks++; if (gnt_vld_o !== 1'b0) begin n_errors++; $display("FAIL single_idle: got %b want 0", gnt_vld_o); end
    n_checks++; if (gnt_o !== 4'b0000) begin n_errors++; $display("FAIL single_gnt0: got %b want 0000", gnt_o); end
    cyc_i = 4'b0001;
    step();
    n_checks++; if (gnt_o !== 4'b0001) begin n_errors++; $display("FAIL single_regrant: got %b want 0001", gnt_o); end
    cyc_i = 4'b1001;
    step();
    n_checks++; if (gnt_o !== 4'b0001) begin n_errors++; $display("FAIL single_keep: got %b want 0001", gnt_o); end
    cyc_i = 4'b1000;
    step();
    n_checks++; if (gnt_o !== 4'b1000) begin n_errors++; $display("FAIL single_handover: got %b want 1000", gnt_o); end
  endtask

  task automatic test_watchdog_fire();
    do_reset();
    cyc_i = 4'b0010;
    stb_i = 4'b0010;
    step();
    for (int i = 1; i <= 11; i++) begin
      step();
      n_checks++; if (to_err_o !== (i == T + 1)) begin n_errors++; $display("FAIL wd_pulse%0d: got %b want %b", i, to_err_o, (i == T + 1)); end
      n_checks++; if (to_err0_o !== 1'b0) begin n_errors++; $display("FAIL wd_disabled%0d: got %b want 0", i, to_err0_o); end
      n_checks++; if (gnt_o !== 4'b0010) begin n_errors++; $display("FAIL wd_hold%0d: got %b want 0010", i, gnt_o); end
    end
    bus_ack_i = 1'b1;
    step();
    bus_ack_i = 1'b0;
    n_checks++; if (to_err_o !== 1'b0) begin n_errors++; $display("FAIL wd_late_ack: got %b want 0", to_err_o); end
    n_checks++; if (gnt_o !== 4'b0010) begin n_errors++; $display("FAIL wd_late_hold: got %b want 0010", gnt_o); end
    lock_i = 4'b0010;
    cyc_i  = 4'b0000;
    stb_i  = 4'b0000;
    step();
    lock_i = 4'b0000;
    n_checks++; if (gnt_o !== 4'b0000) begin n_errors++; $display("FAIL wd_exit: got %b want 0000", gnt_o); end
  endtask

  task automatic test_watchdog_edges();
    do_reset();
    cyc_i = 4'b0001;
    stb_i = 4'b0001;
    step();
    for (int i = 1; i <= T; i++) step();
    bus_ack_i = 1'b1;
    step();
    bus_ack_i = 1'b0;
    n_checks++; if (to_err_o !== 1'b0) begin n_errors++; $display("FAIL wd_ack_wins: got %b want 0", to_err_o); end
    for (int i = T + 2; i <= 2 * T + 2; i++) begin
      step();
      n_checks++; if (to_err_o !== (i == 2 * T + 2)) begin n_errors++; $display("FAIL wd_restart%0d: got %b want %b", i, to_err_o, (i == 2 * T + 2)); end
      n_checks++; if (to_err0_o !== 1'b0) begin n_errors++; $display("FAIL wd_disabled_b%0d: got %b want 0", i, to_err0_o); end
    end
    do_reset();
    cyc_i = 4'b0100;
    stb_i = 4'b0100;
    step();
    for (int i = 1; i <= T; i++) step();
    cyc_i = 4'b0000;
    step();
    stb_i = 4'b0000;
    n_checks++; if (to_err_o !== 1'b0) begin n_errors++; $display("FAIL wd_release_wins: got %b want 0", to_err_o); end
    n_checks++; if (gnt_o !== 4'b0000) begin n_errors++; $display("FAIL wd_release_gnt: got %b want 0000", gnt_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc_i = 4'b1000;
    stb_i = 4'b1000;
    step();
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    n_checks++; if (gnt_o !== 4'b0000) begin n_errors++; $display("FAIL arst_gnt: got %b want 0000", gnt_o); end
    n_checks++; if (gnt_vld_o !== 1'b0) begin n_errors++; $display("FAIL arst_vld: got %b want 0", gnt_vld_o); end
    step();
    rst_i = 1'b0;
    stb_i = 4'b0000;
    cyc_i = 4'b1001;
    step();
    n_checks++; if (gnt_o !== 4'b0001) begin n_errors++; $display("FAIL arst_restart: got %b want 0001", gnt_o); end
    cyc_i = 4'b0010;
    step();
    #2;
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    #1;
    model_reset();
    n_checks++; if (gnt_o !== 4'b0000) begin n_errors++; $display("FAIL arst_pulse_gnt: got %b want 0000", gnt_o); end
    cyc_i = 4'b0110;
    step();
    n_checks++; if (gnt_o !== 4'b0010) begin n_errors++; $display("FAIL arst_ptr: got %b want 0010", gnt_o); end
  endtask

  task automatic test_random();
    logic [N-1:0] exp;
    int drop_max, ack_pct;
    do_reset();
    for (int c = 0; c < 1600; c++) begin
      drop_max = (c < 800) ? 5 : 39;
      ack_pct  = (c < 800) ? 6 : 0;
      for (int m = 0; m < N; m++) begin
        if (cyc_i[m]) begin
          if ($urandom_range(0, drop_max) == 0) cyc_i[m] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          cyc_i[m] = 1'b1;
        end
        stb_i[m]  = cyc_i[m] & ($urandom_range(0, 3) != 0);
        lock_i[m] = cyc_i[m] & ($urandom_range(0, 7) == 0);
      end
      bus_ack_i = ($urandom_range(0, 9) < ack_pct);
      bus_err_i = (c < 800) && ($urandom_range(0, 29) == 0);
      bus_rty_i = (c < 800) && ($urandom_range(0, 29) == 0);
      step();
      exp = '0;
      if (m_owner >= 0) exp[m_owner] = 1'b1;
      n_checks++; if (gnt_o !== exp) begin n_errors++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, gnt_o, exp); end
      n_checks++; if (gnt_vld_o !== (m_owner >= 0)) begin n_errors++; $display("FAIL rnd_vld@%0d: got %b want %b", c, gnt_vld_o, (m_owner >= 0)); end
      if (m_owner >= 0) begin
        n_checks++; if (gnt_idx_o !== 2'(m_owner)) begin n_errors++; $display("FAIL rnd_idx@%0d: got %0d want %0d", c, gnt_idx_o, m_owner); end
      end
      n_checks++; if (to_err_o !== m_err) begin n_errors++; $display("FAIL rnd_to_err@%0d: got %b want %b", c, to_err_o, m_err); end
      n_checks++; if (to_err0_o !== 1'b0) begin n_errors++; $display("FAIL rnd_disabled@%0d: got %b want 0", c, to_err0_o); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_lock();
    test_single();
    test_watchdog_fire();
    test_watchdog_edges();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter.md
# wishbone_arbiter

Sequential round-robin master arbiter for the shared wishbone interconnect. Arbitrates `cyc_i` requests from up to N_MASTER masters and issues a one-hot grant consumed by the interconnect's master mux. Honours per-master bus lock and runs a bus-watchdog that terminates stalled cycles with an error pulse. Replaces fixed-priority selection, so low-index masters cannot starve the others.

## Interface
- N_MASTER, 4: number of masters; valid range 2..16.
- TIMEOUT, 255: cycles of unanswered `stb` before watchdog fires; 0 disables the watchdog.
- IDX_W, $clog2(N_MASTER): derived; width of the grant index.
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- cyc_i  in  N_MASTER  per-master cycle request.
- stb_i  in  N_MASTER  per-master strobe.
- lock_i  in  N_MASTER  per-master lock; holds the grant across cycles.
- bus_ack_i  in  1  ack from the selected slave path.
- bus_err_i  in  1  err from the selected slave path.
- bus_rty_i  in  1  rty from the selected slave path.
- gnt_o  out  N_MASTER  one-hot grant, or all-zero.
- gnt_idx_o  out  IDX_W  index of the granted master; valid when `gnt_vld_o` is 1.
- gnt_vld_o  out  1  a grant is active.
- to_err_o  out  1  one-cycle watchdog error to the granted master; OR-ed into `sm_err_o` externally.

## Operation
- State machine `IDLE`, `GRANT`, `TIMEOUT`.
- Registers: `state_q`, `gnt_idx_q`, `last_q` (round-robin pointer), `to_cnt_q`.

**Arbitration**
- Search order is `last_q+1, last_q+2, …` modulo N_MASTER.
- The first index with `cyc_i` high wins.

**IDLE**
- Any `cyc_i` high → `GRANT` with the winner.
- Set `last_q` to the winner.

**GRANT (master g)**
- Release condition: `cyc_i[g]`=0 and `lock_i[g]`=0.
- On release, if any other `cyc_i` is high, re-arbitrate that same cycle and go directly to `GRANT` on the new winner (no dead cycle).
- On release with no other request, go to `IDLE`.
- If `lock_i[g]`=1, the grant is held even while `cyc_i[g]`=0.

**Watchdog**
- `to_cnt_q` increments while in `GRANT`, `stb_i[g]`=1 and ack/err/rty are all 0.
- It clears on any response, on `stb_i[g]`=0, and on any grant change.
- It saturates at TIMEOUT.
- When the count reaches TIMEOUT with no response this cycle:
  - pulse `to_err_o` for one cycle;
  - go to `TIMEOUT`.

**TIMEOUT**
- The grant is held.
- Go to `IDLE` once `cyc_i[g]`=0; `lock_i` is ignored here.
- Any late slave response is not forwarded as a new event (`to_err_o` stays 0).

**Boundary cases**
- Release and timeout in the same cycle: release wins, `to_err_o`=0.
- Response in the same cycle the count reaches TIMEOUT: response wins, counter clears.
- Single requester: re-granted repeatedly; the pointer stays on it.
- All-zero `cyc_i`: `gnt_o`=0.

## Timing
- Reset values:
  - `gnt_o`=0, `gnt_vld_o`=0, `gnt_idx_o`=0, `to_err_o`=0;
  - `state_q`=`IDLE`, `to_cnt_q`=0;
  - `last_q`=N_MASTER-1, so master 0 has first priority.
- Grant latency: `cyc_i` rising at edge k in `IDLE` → `gnt_o` valid after edge k+1.
- Handover: release sampled at edge k → new grant after edge k+1. No cycle exists with two bits set.
- All outputs are registered; none are combinational from inputs.
- `to_err_o` is asserted after edge k+TIMEOUT, where k is the first edge sampling unanswered `stb`.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronously); arbitration after deassert restarts from master 0.

## Structure
- `wishbone_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, GRANT, TIMEOUT} arb_state_e`;
  - the default TIMEOUT constant.
- Sub-module `rr_picker`: combinational rotate-priority encoder.
  - Inputs: `req[N]`, `ptr[IDX_W]`.
  - Outputs: `idx`, `found`.
  - Reusable by the slave side later.
- Counter width is `$clog2(TIMEOUT+1)`; when TIMEOUT=0, tie the counter off.

## Test plan
- **Reset priority:** after reset, `cyc_i`=4'b1010 → `gnt_o`=4'b0010 one cycle later, `gnt_idx_o`=1.
- **Round-robin fairness:** `cyc_i`=4'b1111 held, each master drops `cyc` after 3 cycles and re-raises → grant order 0,1,2,3,0 with no idle cycles.
- **Lock hold:** master 2 granted, `lock_i[2]`=1, `cyc_i[2]` drops, `cyc_i[0]`=1 → grant stays 4'b0100 until `lock_i[2]`=0, then 4'b0001 next cycle.
- **Watchdog fire:** TIMEOUT=8, master 1 `stb` held, no ack → `to_err_o` is a single pulse 8 cycles after the first unanswered `stb`; state `TIMEOUT` until `cyc_i[1]`=0.
- **Watchdog edges:**
  - ack arrives on cycle 8 → no `to_err_o`;
  - `cyc` drops on cycle 8 → no `to_err_o`;
  - TIMEOUT=0 → never fires.
- **Reset mid-grant:** master 3 granted, `rst_i` pulsed asynchronously → `gnt_o`=0 immediately; after release with `cyc_i`=4'b1001 → master 0 granted.
